priority_request_capture: RTL and testbench

- Upstream stage for the priority encoder / 7-segment decoder.
- Takes 8 raw asynchronous request lines (switches or buttons) and synchronizes and debounces each one.
- Captures each rising edge as a sticky pending bit, so short requests are not lost before they are displayed.
- pending_o drives the encoder's data input. An ack port clears the bit whose index the encoder currently shows.

---
 rtl/priority_request_capture_pkg.sv | 16 +
 rtl/priority_request_capture_if.sv | 30 +++
 rtl/priority_request_capture_debounce_channel.sv | 47 ++++
 rtl/priority_request_capture.sv | 80 ++++++++
 tb/tb_priority_request_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/priority_request_capture_pkg.sv
// Shared constants, width helper and channel index type for the request
// capture stage and the priority encoder that consumes its pending bits.
package priority_request_capture_pkg;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Bits needed to hold 0..n-1; never less than one so n == 1 still has a field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(DEFAULT_WIDTH)-1:0] chan_idx_t;

endpackage

// File: rtl/priority_request_capture_if.sv
// Request/ack/status bundle between the request capture stage and its user.
interface priority_request_capture_if
    import priority_request_capture_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    localparam int IW = idx_width(WIDTH);

    logic [WIDTH-1:0] req_in;
    logic             ack_valid;
    logic [IW-1:0]    ack_idx;
    logic             clear_all;
    logic [WIDTH-1:0] pending_o;
    logic             any_o;
    logic [WIDTH-1:0] stable_o;
    logic             new_o;
    logic [WIDTH-1:0] overrun_o;

    modport master (
        output req_in, ack_valid, ack_idx, clear_all,
        input  pending_o, any_o, stable_o, new_o, overrun_o
    );

    modport slave (
        input  req_in, ack_valid, ack_idx, clear_all,
        output pending_o, any_o, stable_o, new_o, overrun_o
    );

endinterface

// File: rtl/priority_request_capture_debounce_channel.sv
// One request line: synchronizer chain, debounce counter, stable level and
// a rise strobe that is valid on the same edge the stable level goes high.
module priority_request_capture_debounce_channel
    import priority_request_capture_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = idx_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CW-1:0]          count;
    logic                   sync_level;
    logic                   accept;

    assign sync_level = sync_chain[SYNC_STAGES-1];
    assign accept     = (sync_level != stable) && (count == LAST);
    // Combinational so the top can capture the event on the edge stable updates.
    assign rise       = accept && sync_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
            count      <= '0;
            stable     <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
            if (sync_level == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                stable <= sync_level;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_request_capture.sv
// Debounced, sticky request capture feeding the priority encoder; the encoder
// acknowledges the channel it is showing to clear that pending bit.
module priority_request_capture
    import priority_request_capture_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic clk,
    input logic rst,
    priority_request_capture_if.slave bus
);

    localparam int IW = idx_width(WIDTH);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] overrun_q;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] overrun_next;
    logic             any_q;
    logic             new_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        priority_request_capture_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .raw    (bus.req_in[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );

        // Out-of-range indices simply never match any channel.
        assign clr[i] = bus.clear_all || (bus.ack_valid && (bus.ack_idx == IW'(i)));
    end

    // A rise beats a same-edge clear so a fresh request is never swallowed.
    always_comb begin
        pending_next = pending_q;
        overrun_next = overrun_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (rise[i]) begin
                pending_next[i] = 1'b1;
                if (pending_q[i] && !clr[i]) begin
                    overrun_next[i] = 1'b1;
                end
            end else if (clr[i]) begin
                pending_next[i] = 1'b0;
                overrun_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
            any_q     <= 1'b0;
            new_q     <= 1'b0;
        end else begin
            pending_q <= pending_next;
            overrun_q <= overrun_next;
            any_q     <= |pending_next;
            new_q     <= |(pending_next & ~pending_q);
        end
    end

    assign bus.pending_o = pending_q;
    assign bus.overrun_o = overrun_q;
    assign bus.stable_o  = stable;
    assign bus.any_o     = any_q;
    assign bus.new_o     = new_q;

endmodule

// File: tb/tb_priority_request_capture.sv
// Bench for priority_request_capture: directed scenarios with literal checks,
// then random stimulus compared every cycle against a behavioural model.
module tb_priority_request_capture;
    import priority_request_capture_pkg::*;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic clk;
    logic rst;
    logic cmp_en;
    int   checks   = 0;
    int   failures = 0;

    priority_request_capture_if #(.WIDTH(W)) bus ();

    priority_request_capture #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: raw samples per edge since reset; a channel flips its stable level
    // when the last D synchronized samples (raw delayed by S edges) all disagree.
    logic [7:0] hist[$];
    logic [7:0] m_stable, m_pending, m_overrun;
    logic       m_any, m_new;
    logic [7:0] st, pn, ov, rz, h;
    int         n, m;
    bit         flip, clr_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            m_stable  <= '0;
            m_pending <= '0;
            m_overrun <= '0;
            m_any     <= 1'b0;
            m_new     <= 1'b0;
        end else begin
            hist.push_back(bus.req_in);
            n  = hist.size() - 1;
            st = m_stable;
            rz = '0;
            for (int c = 0; c < W; c++) begin
                flip = 1'b1;
                for (int k = 0; k < D; k++) begin
                    m = n - k - S;
                    if (m >= 0) begin
                        h = hist[m];
                        if (h[c] == m_stable[c]) flip = 1'b0;
                    end else if (m_stable[c] == 1'b0) begin
                        flip = 1'b0;
                    end
                end
                if (flip) begin
                    st[c] = ~m_stable[c];
                    rz[c] = st[c];
                end
            end
            pn = m_pending;
            ov = m_overrun;
            for (int c = 0; c < W; c++) begin
                clr_c = bus.clear_all || (bus.ack_valid && (int'(bus.ack_idx) == c));
                if (rz[c]) begin
                    if (m_pending[c] && !clr_c) ov[c] = 1'b1;
                    pn[c] = 1'b1;
                end else if (clr_c) begin
                    pn[c] = 1'b0;
                    ov[c] = 1'b0;
                end
            end
            m_stable  <= st;
            m_pending <= pn;
            m_overrun <= ov;
            m_any     <= (pn != 8'h00);
            m_new     <= ((pn & ~m_pending) != 8'h00);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic av, input chan_idx_t idx,
                                 input logic ca, input int cycles);
        bus.req_in    = req;
        bus.ack_valid = av;
        bus.ack_idx   = idx;
        bus.clear_all = ca;
        repeat (cycles) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_pending", bus.pending_o, m_pending);
            checkOutput("model_stable", bus.stable_o, m_stable);
            checkOutput("model_overrun", bus.overrun_o, m_overrun);
            checkOutput("model_any", {7'b0, bus.any_o}, {7'b0, m_any});
            checkOutput("model_new", {7'b0, bus.new_o}, {7'b0, m_new});
        end
    end

    logic [7:0] rq;
    int         b;
    int         r;

    initial begin
        rst           = 1'b1;
        cmp_en        = 1'b0;
        bus.req_in    = 8'hFF;
        bus.ack_valid = 1'b0;
        bus.ack_idx   = '0;
        bus.clear_all = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("reset_pending", bus.pending_o, 8'h00);
        checkOutput("reset_stable", bus.stable_o, 8'h00);
        checkOutput("reset_new", {7'b0, bus.new_o}, 8'h00);

        rst = 1'b0;
        applyStimulus(8'h00, 1'b0, 3'd0, 1'b0, 10);
        checkOutput("release_pending", bus.pending_o, 8'h00);
        checkOutput("release_any", {7'b0, bus.any_o}, 8'h00);

        // Clean press on channel 5: visible on the sixth edge after the change.
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 5);
        checkOutput("press_early_stable", bus.stable_o, 8'h00);
        checkOutput("press_early_pending", bus.pending_o, 8'h00);
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 1);
        checkOutput("press_stable", bus.stable_o, 8'h20);
        checkOutput("press_pending", bus.pending_o, 8'h20);
        checkOutput("press_any", {7'b0, bus.any_o}, 8'h01);
        checkOutput("press_new", {7'b0, bus.new_o}, 8'h01);
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 1);
        checkOutput("press_new_drop", {7'b0, bus.new_o}, 8'h00);

        applyStimulus(8'h24, 1'b0, 3'd0, 1'b0, 3);
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 10);
        checkOutput("glitch_pending", bus.pending_o, 8'h20);
        checkOutput("glitch_stable", bus.stable_o, 8'h20);
        applyStimulus(8'h24, 1'b0, 3'd0, 1'b0, 8);
        checkOutput("long_pending", bus.pending_o, 8'h24);
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 8);
        checkOutput("release2_pending", bus.pending_o, 8'h24);

        applyStimulus(8'hA0, 1'b0, 3'd0, 1'b0, 8);
        checkOutput("press7_pending", bus.pending_o, 8'hA4);
        applyStimulus(8'hA0, 1'b1, 3'd2, 1'b0, 1);
        checkOutput("ack2_pending", bus.pending_o, 8'hA0);
        applyStimulus(8'hA0, 1'b1, 3'd7, 1'b0, 1);
        checkOutput("ack7_pending", bus.pending_o, 8'h20);
        applyStimulus(8'h20, 1'b0, 3'd0, 1'b0, 8);
        applyStimulus(8'hA0, 1'b0, 3'd0, 1'b0, 6);
        checkOutput("repress7_pending", bus.pending_o, 8'hA0);
        checkOutput("repress7_new", {7'b0, bus.new_o}, 8'h01);
        applyStimulus(8'hA0, 1'b1, 3'd0, 1'b0, 1);
        checkOutput("ack_idle_pending", bus.pending_o, 8'hA0);

        applyStimulus(8'hA8, 1'b0, 3'd0, 1'b0, 8);
        applyStimulus(8'hA0, 1'b0, 3'd0, 1'b0, 8);
        applyStimulus(8'hA8, 1'b0, 3'd0, 1'b0, 8);
        checkOutput("overrun_flag", bus.overrun_o, 8'h08);
        checkOutput("overrun_pending", bus.pending_o, 8'hA8);
        applyStimulus(8'hA8, 1'b0, 3'd0, 1'b1, 1);
        checkOutput("clear_pending", bus.pending_o, 8'h00);
        checkOutput("clear_overrun", bus.overrun_o, 8'h00);

        // Rise on channel 1 coincides with ack of channel 1 and clear_all.
        applyStimulus(8'h00, 1'b0, 3'd0, 1'b0, 8);
        applyStimulus(8'h88, 1'b0, 3'd0, 1'b0, 8);
        checkOutput("pre_collide_pending", bus.pending_o, 8'h88);
        applyStimulus(8'h8A, 1'b0, 3'd0, 1'b0, 5);
        applyStimulus(8'h8A, 1'b1, 3'd1, 1'b1, 1);
        checkOutput("collide_pending", bus.pending_o, 8'h02);
        checkOutput("collide_overrun", bus.overrun_o, 8'h00);
        checkOutput("collide_new", {7'b0, bus.new_o}, 8'h01);

        rq = 8'h8A;
        for (int seg = 0; seg < 300; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end else begin
                if (r < 60) begin
                    b     = $urandom_range(0, W - 1);
                    rq[b] = ~rq[b];
                end
                applyStimulus(rq, ($urandom_range(0, 3) == 0), chan_idx_t'($urandom_range(0, W - 1)),
                              ($urandom_range(0, 19) == 0), 1);
                applyStimulus(rq, 1'b0, 3'd0, 1'b0, $urandom_range(0, 10));
            end
        end

        applyStimulus(rq, 1'b0, 3'd0, 1'b0, 12);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
